// File: rtl/route_reserve_allocator_if.sv
// Request/grant/release bundle between input-port head-flit logic and the route reservation allocator.
// Handshake: a requester holds routeReserveRequestValid[i] with a stable index until it sees the one-cycle
// routeReserveStatus[i] pulse; it then owns the output until it pulses routeRelieve[i] for one cycle.
interface route_reserve_allocator_if #(
  parameter int NUM_IN        = 5,
  parameter int NUM_OUT       = 5,
  parameter int REQUEST_WIDTH = 3
);
  localparam int SEL_WIDTH = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0]               routeReserveRequestValid;
  logic [NUM_IN*REQUEST_WIDTH-1:0] routeReserveRequest;
  logic [NUM_IN-1:0]               routeRelieve;
  logic [NUM_IN-1:0]               routeReserveStatus;
  logic [NUM_OUT*SEL_WIDTH-1:0]    outSelect;
  logic [NUM_OUT-1:0]              outBusy;
  logic                            reqError;
  logic [2*NUM_OUT-1:0]            state_dbg;

  modport master (
    output routeReserveRequestValid, routeReserveRequest, routeRelieve,
    input  routeReserveStatus, outSelect, outBusy, reqError, state_dbg
  );

  modport slave (
    input  routeReserveRequestValid, routeReserveRequest, routeRelieve,
    output routeReserveStatus, outSelect, outBusy, reqError, state_dbg
  );
endinterface

// File: rtl/route_reserve_allocator.sv
// Per-output round-robin route reservation: FREE -> GRANT (one-cycle status pulse) -> HELD until the
// owner relieves. Every output is registered; state_dbg exposes each output's FSM state.
module route_reserve_allocator #(
  parameter int NUM_IN        = 5,
  parameter int NUM_OUT       = 5,
  parameter int REQUEST_WIDTH = 3
) (
  input logic                      clk,
  input logic                      rst,
  route_reserve_allocator_if.slave bus
);
  localparam int SEL_WIDTH = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  state_t               state_q [NUM_OUT];
  logic [SEL_WIDTH-1:0] owner_q [NUM_OUT];
  logic [SEL_WIDTH-1:0] rr_q    [NUM_OUT];
  logic [NUM_IN-1:0]    status_q;
  logic [NUM_OUT-1:0]   busy_q;
  logic                 err_q;

  logic [NUM_IN-1:0]    owns;
  logic [NUM_OUT-1:0]   grant_hit;
  logic [SEL_WIDTH-1:0] grant_idx [NUM_OUT];
  logic [SEL_WIDTH-1:0] grant_rr  [NUM_OUT];
  logic                 bad_req;

  // An input in GRANT or HELD on any output counts as owning; this also blocks a second grant in flight.
  always_comb begin
    owns = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      if (state_q[o] != ST_FREE) owns[owner_q[o]] = 1'b1;
    end
  end

  always_comb begin
    bad_req = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.routeReserveRequestValid[i] && !owns[i] &&
          int'(bus.routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH]) >= NUM_OUT)
        bad_req = 1'b1;
    end
  end

  // Round-robin search from rr_q[o]; only FREE outputs arbitrate, so a just-relieved output waits a cycle.
  always_comb begin
    int cand;
    cand = 0;
    for (int o = 0; o < NUM_OUT; o++) begin
      grant_hit[o] = 1'b0;
      grant_idx[o] = '0;
      grant_rr[o]  = '0;
      if (state_q[o] == ST_FREE) begin
        for (int k = 0; k < NUM_IN; k++) begin
          cand = int'(rr_q[o]) + k;
          if (cand >= NUM_IN) cand = cand - NUM_IN;
          if (!grant_hit[o] && bus.routeReserveRequestValid[cand] && !owns[cand] &&
              bus.routeReserveRequest[cand*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(o)) begin
            grant_hit[o] = 1'b1;
            grant_idx[o] = SEL_WIDTH'(cand);
            grant_rr[o]  = (cand + 1 >= NUM_IN) ? '0 : SEL_WIDTH'(cand + 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        state_q[o] <= ST_FREE;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
      end
      status_q <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      status_q <= '0;
      if (bad_req) err_q <= 1'b1;
      for (int o = 0; o < NUM_OUT; o++) begin
        case (state_q[o])
          ST_FREE: begin
            if (grant_hit[o]) begin
              state_q[o]             <= ST_GRANT;
              owner_q[o]             <= grant_idx[o];
              rr_q[o]                <= grant_rr[o];
              status_q[grant_idx[o]] <= 1'b1;
              busy_q[o]              <= 1'b1;
            end
          end
          ST_GRANT: state_q[o] <= ST_HELD;
          ST_HELD: begin
            if (bus.routeRelieve[owner_q[o]]) begin
              state_q[o] <= ST_FREE;
              busy_q[o]  <= 1'b0;
            end
          end
          default: begin
            state_q[o] <= ST_FREE;
            busy_q[o]  <= 1'b0;
          end
        endcase
      end
    end
  end

  // outSelect keeps the last owner while FREE; consumers qualify it with outBusy.
  always_comb begin
    bus.outSelect = '0;
    bus.state_dbg = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      bus.outSelect[o*SEL_WIDTH +: SEL_WIDTH] = owner_q[o];
      bus.state_dbg[2*o +: 2]                 = state_q[o];
    end
  end

  assign bus.routeReserveStatus = status_q;
  assign bus.outBusy            = busy_q;
  assign bus.reqError           = err_q;
endmodule
